// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the 5-stage CPU.
// Carries a valid bit, a control bundle and a data bundle with stall-hold and
// flush-bubble behaviour. It also keeps saturating stall/bubble counters and a
// sticky stall watchdog for hazard-unit debug. The counters and the watchdog
// never feed back into the datapath.
module pipe_stage_reg #(
    parameter int                CTRL_W    = 16,
    parameter int                DATA_W    = 128,
    parameter logic [CTRL_W-1:0] CTRL_NOP  = '0,
    parameter int                CNT_W     = 16,
    parameter int                STALL_MAX = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              stall_timeout
);

    // A zero-length run counter is not legal, so keep one dummy bit when the
    // watchdog is disabled; it is then tied to zero.
    localparam int               RUN_W   = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic              valid_q,   valid_d;
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [RUN_W-1:0]  run_q,     run_d;
    logic              timeout_q, timeout_d;

    logic eff_stall;
    logic bubble;

    // flush wins over stall, so only a stall without flush is a real hold
    assign eff_stall = stall & ~flush;
    assign bubble    = flush | (~stall & ~in_valid);

    // Datapath next state: flush bubbles, stall holds, otherwise load upstream
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (!stall) begin
            valid_d = in_valid;
            ctrl_d  = in_valid ? ctrl_in : CTRL_NOP;
            data_d  = data_in;
        end
    end

    // Debug next state: saturating counters, stall-run watchdog, clear wins
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        run_d        = '0;
        timeout_d    = timeout_q;

        if (eff_stall && (stall_cnt_q != CNT_SAT)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bubble && (bubble_cnt_q != CNT_SAT)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end

        if (STALL_MAX == 0) begin
            run_d     = '0;
            timeout_d = 1'b0;
        end else begin
            if (eff_stall) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end
            // run_d is zero on any non-stall cycle, so this only fires
            // when a consecutive stall run reaches the limit
            if (run_d == RUN_MAX) begin
                timeout_d = 1'b1;
            end
        end

        if (clr_cnt) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
            run_d        = '0;
            timeout_d    = 1'b0;
        end
    end

    // State registers; asynchronous reset discards everything, even mid-stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            data_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            run_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            run_q        <= run_d;
            timeout_q    <= timeout_d;
        end
    end

    assign out_valid     = valid_q;
    assign ctrl_out      = ctrl_q;
    assign data_out      = data_q;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign stall_timeout = timeout_q;

endmodule
